// File: rtl/complex_fir_feeder_if.sv
// complex_fir_feeder_if: control, coefficient-write, sample-stream and FIR-side
// signals of the complex FIR feeder. The master modport is the feeder's view;
// the slave modport is the view of the block that drives it (upstream source,
// coefficient writer and FIR-side observer).
interface complex_fir_feeder_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
);
  localparam int unsigned SAMPLE_WIDTH = DATA_WIDTH * 3;

  // frame control
  logic                    start;
  logic                    busy;
  logic                    done;

  // coefficient store write port
  logic                    coeffWrEn;
  logic [ADDR_WIDTH-1:0]   coeffWrAddr;
  logic [DATA_WIDTH-1:0]   coeffWrRe;
  logic [DATA_WIDTH-1:0]   coeffWrIm;

  // upstream sample stream
  logic                    inValid;
  logic                    inLast;
  logic [SAMPLE_WIDTH-1:0] inRe;
  logic [SAMPLE_WIDTH-1:0] inIm;
  logic                    inReady;

  // FIR load/flag outputs
  logic                    loadCoeff;
  logic                    coeffSetFlag;
  logic [DATA_WIDTH-1:0]   coeffOutRe;
  logic [DATA_WIDTH-1:0]   coeffOutIm;
  logic                    loadDataFlag;
  logic                    stopDataLoadFlag;
  logic [SAMPLE_WIDTH-1:0] dataOutRe;
  logic [SAMPLE_WIDTH-1:0] dataOutIm;

  modport master (
    input  start, coeffWrEn, coeffWrAddr, coeffWrRe, coeffWrIm,
    input  inValid, inLast, inRe, inIm,
    output inReady, loadCoeff, coeffSetFlag, coeffOutRe, coeffOutIm,
    output loadDataFlag, stopDataLoadFlag, dataOutRe, dataOutIm,
    output busy, done
  );

  modport slave (
    output start, coeffWrEn, coeffWrAddr, coeffWrRe, coeffWrIm,
    output inValid, inLast, inRe, inIm,
    input  inReady, loadCoeff, coeffSetFlag, coeffOutRe, coeffOutIm,
    input  loadDataFlag, stopDataLoadFlag, dataOutRe, dataOutIm,
    input  busy, done
  );
endinterface

// File: rtl/complex_fir_feeder.sv
// complex_fir_feeder: initiator-side sequencer for the complex n-tap FIR.
// Per start pulse: loadCoeff, coefficient stream aligned to the FIR's 3-stage
// coefficient pre-buffer, settle with coeffSetFlag, forwarded valid/ready
// sample stream, LENGTH zero flush pushes, stopDataLoadFlag, done.
// All outputs are registered. Optional build macro
// COMPLEX_FIR_FEEDER_CONJ_COEFF_EN streams conj(store[LENGTH-1-k]) with
// saturating negation of the imaginary part.
module complex_fir_feeder #(
  parameter int unsigned LENGTH     = 12,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                 clock,
  input  logic                 resetN,
  complex_fir_feeder_if.master bus
);

  localparam int unsigned SAMPLE_WIDTH = DATA_WIDTH * 3;
  // counter must reach LENGTH-1 (COEFF/FLUSH) and 2 (SETTLE)
  localparam int unsigned CNT_MAX      = (LENGTH > 3) ? LENGTH : 3;
  localparam int unsigned CNT_W        = $clog2(CNT_MAX);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(LENGTH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_COEFF,
    S_SETTLE,
    S_STREAM,
    S_FLUSH,
    S_STOP,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    last_q, last_d;

  logic [DATA_WIDTH-1:0]   store_re_q [LENGTH];
  logic [DATA_WIDTH-1:0]   store_im_q [LENGTH];
  logic [DATA_WIDTH-1:0]   store_re_d [LENGTH];
  logic [DATA_WIDTH-1:0]   store_im_d [LENGTH];

  logic                    in_ready_q, in_ready_d;
  logic                    load_coeff_q, load_coeff_d;
  logic                    coeff_set_q, coeff_set_d;
  logic [DATA_WIDTH-1:0]   coeff_re_q, coeff_re_d;
  logic [DATA_WIDTH-1:0]   coeff_im_q, coeff_im_d;
  logic                    load_data_q, load_data_d;
  logic                    stop_q, stop_d;
  logic [SAMPLE_WIDTH-1:0] data_re_q, data_re_d;
  logic [SAMPLE_WIDTH-1:0] data_im_q, data_im_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  logic                    xfer;
  logic                    wr_ok;
  logic [DATA_WIDTH-1:0]   coeff_sel_re;
  logic [DATA_WIDTH-1:0]   coeff_sel_im;

`ifdef COMPLEX_FIR_FEEDER_CONJ_COEFF_EN
  localparam logic [DATA_WIDTH-1:0] D_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] D_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};

  function automatic logic [DATA_WIDTH-1:0] sat_neg(input logic [DATA_WIDTH-1:0] v);
    return (v == D_MIN) ? D_MAX : (~v + DATA_WIDTH'(1));
  endfunction
`endif

  // a sample moves only when the registered ready is presented
  assign xfer = bus.inValid && in_ready_q;

  // coefficient store write decode; the decode only covers 0..LENGTH-1, so
  // out-of-range addresses match nothing and are dropped
  always_comb begin
    store_re_d = store_re_q;
    store_im_d = store_im_q;
    wr_ok      = bus.coeffWrEn && !busy_q;
    for (int unsigned i = 0; i < LENGTH; i++) begin
      if (wr_ok && (bus.coeffWrAddr == ADDR_WIDTH'(i))) begin
        store_re_d[i] = bus.coeffWrRe;
        store_im_d[i] = bus.coeffWrIm;
      end
    end
  end

  // next state, phase counter and end-of-stream marker
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_ARM;
      S_ARM:    state_d = S_WAIT;
      S_WAIT: begin
        state_d = S_COEFF;
        cnt_d   = '0;
      end
      S_COEFF: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          state_d = S_STREAM;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      // the cycle after the inLast transfer stays in STREAM with ready low so
      // the final sample is presented before the LENGTH zero pushes of FLUSH
      S_STREAM: begin
        if (last_q) begin
          state_d = S_FLUSH;
          cnt_d   = '0;
          last_d  = 1'b0;
        end else if (xfer && bus.inLast) begin
          last_d = 1'b1;
        end
      end
      S_FLUSH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_STOP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_STOP:   state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        last_d  = 1'b0;
      end
    endcase
  end

  // coefficient selected for the upcoming COEFF cycle
  always_comb begin
    coeff_sel_re = '0;
    coeff_sel_im = '0;
    for (int unsigned i = 0; i < LENGTH; i++) begin
`ifdef COMPLEX_FIR_FEEDER_CONJ_COEFF_EN
      if (cnt_d == CNT_W'(LENGTH - 1 - i)) begin
        coeff_sel_re = store_re_q[i];
        coeff_sel_im = sat_neg(store_im_q[i]);
      end
`else
      if (cnt_d == CNT_W'(i)) begin
        coeff_sel_re = store_re_q[i];
        coeff_sel_im = store_im_q[i];
      end
`endif
    end
  end

  // outputs decoded from the next state so the registered copies line up
  // with the state they describe
  always_comb begin
    load_coeff_d = (state_d == S_ARM);
    coeff_set_d  = (state_d == S_SETTLE) && (cnt_d == SETTLE_LAST);
    coeff_re_d   = (state_d == S_COEFF) ? coeff_sel_re : '0;
    coeff_im_d   = (state_d == S_COEFF) ? coeff_sel_im : '0;
    in_ready_d   = (state_d == S_STREAM) && !last_d;
    load_data_d  = xfer || (state_d == S_FLUSH);
    stop_d       = (state_d == S_STOP);
    done_d       = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
    data_re_d    = '0;
    data_im_d    = '0;
    if (xfer) begin
      data_re_d = bus.inRe;
      data_im_d = bus.inIm;
    end else if (state_d == S_STREAM) begin
      data_re_d = data_re_q;
      data_im_d = data_im_q;
    end
  end

  // state, counters, coefficient store and registered outputs
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      for (int unsigned i = 0; i < LENGTH; i++) begin
        store_re_q[i] <= '0;
        store_im_q[i] <= '0;
      end
      in_ready_q   <= 1'b0;
      load_coeff_q <= 1'b0;
      coeff_set_q  <= 1'b0;
      coeff_re_q   <= '0;
      coeff_im_q   <= '0;
      load_data_q  <= 1'b0;
      stop_q       <= 1'b0;
      data_re_q    <= '0;
      data_im_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      store_re_q   <= store_re_d;
      store_im_q   <= store_im_d;
      in_ready_q   <= in_ready_d;
      load_coeff_q <= load_coeff_d;
      coeff_set_q  <= coeff_set_d;
      coeff_re_q   <= coeff_re_d;
      coeff_im_q   <= coeff_im_d;
      load_data_q  <= load_data_d;
      stop_q       <= stop_d;
      data_re_q    <= data_re_d;
      data_im_q    <= data_im_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.inReady          = in_ready_q;
  assign bus.loadCoeff        = load_coeff_q;
  assign bus.coeffSetFlag     = coeff_set_q;
  assign bus.coeffOutRe       = coeff_re_q;
  assign bus.coeffOutIm       = coeff_im_q;
  assign bus.loadDataFlag     = load_data_q;
  assign bus.stopDataLoadFlag = stop_q;
  assign bus.dataOutRe        = data_re_q;
  assign bus.dataOutIm        = data_im_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;

endmodule

// File: tb/tb_complex_fir_feeder.sv
// tb_complex_fir_feeder: scoreboard bench for complex_fir_feeder (LENGTH=4).
// Stimulus pushes time-stamped expected output snapshots; a negedge monitor
// pops and compares whenever one is due or any strobe appears.
module tb_complex_fir_feeder;
  localparam int unsigned L  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned SW = DW * 3;
  localparam int unsigned IW = $clog2(L);

  logic clock  = 1'b0;
  logic resetN = 1'b0;

  complex_fir_feeder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  complex_fir_feeder #(.LENGTH(L), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic          lc;
    logic          cs;
    logic [DW-1:0] cre;
    logic [DW-1:0] cim;
    logic          ld;
    logic [SW-1:0] dre;
    logic [SW-1:0] dim;
    logic          stop;
    logic          done;
    logic          busy;
  } obs_t;

  typedef struct {
    int   cyc;
    obs_t o;
  } exp_t;

  exp_t          q[$];
  int            cyc      = 0;
  int            checks   = 0;
  int            errors   = 0;
  bit            mon_en   = 1'b0;
  bit            tb_busy  = 1'b0;
  int            done_cyc = 0;
  logic [DW-1:0] m_re [L];
  logic [DW-1:0] m_im [L];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic obs_t sample_dut();
    obs_t o;
    o.lc   = bus.loadCoeff;
    o.cs   = bus.coeffSetFlag;
    o.cre  = bus.coeffOutRe;
    o.cim  = bus.coeffOutIm;
    o.ld   = bus.loadDataFlag;
    o.dre  = bus.dataOutRe;
    o.dim  = bus.dataOutIm;
    o.stop = bus.stopDataLoadFlag;
    o.done = bus.done;
    o.busy = bus.busy;
    return o;
  endfunction

  function automatic obs_t ev_busy();
    obs_t o;
    o      = '0;
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic logic [DW-1:0] sat_neg(input logic [DW-1:0] v);
    return (v == 8'h80) ? 8'h7f : (~v + 8'd1);
  endfunction

  task automatic push(input int c, input obs_t o);
    exp_t e;
    e.cyc = c;
    e.o   = o;
    q.push_back(e);
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    obs_t a;
    exp_t e;
    if (mon_en) begin
      a = sample_dut();
      if (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_event at cyc %0d: was due at cyc %0d", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        checks++;
        if (a !== e.o) begin
          errors++;
          $display("FAIL event cyc %0d actual lc=%0b cs=%0b c=(%0d,%0d) ld=%0b d=(%0d,%0d) stop=%0b done=%0b busy=%0b required lc=%0b cs=%0b c=(%0d,%0d) ld=%0b d=(%0d,%0d) stop=%0b done=%0b busy=%0b",
                   cyc, a.lc, a.cs, $signed(a.cre), $signed(a.cim), a.ld, $signed(a.dre), $signed(a.dim), a.stop, a.done, a.busy,
                   e.o.lc, e.o.cs, $signed(e.o.cre), $signed(e.o.cim), e.o.ld, $signed(e.o.dre), $signed(e.o.dim), e.o.stop, e.o.done, e.o.busy);
        end
      end else if (a.lc || a.cs || a.ld || a.stop || a.done) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe cyc %0d actual lc=%0b cs=%0b ld=%0b stop=%0b done=%0b required none",
                 cyc, a.lc, a.cs, a.ld, a.stop, a.done);
      end
    end
  end

  task automatic wr(input int a, input int re, input int im);
    bus.coeffWrEn   = 1'b1;
    bus.coeffWrAddr = AW'(a);
    bus.coeffWrRe   = DW'(re);
    bus.coeffWrIm   = DW'(im);
    if (!tb_busy && a >= 0 && a < L) begin
      m_re[IW'(a)] = DW'(re);
      m_im[IW'(a)] = DW'(im);
    end
    @(negedge clock);
    bus.coeffWrEn = 1'b0;
  endtask

  // pulse start (optionally with a simultaneous write) and push the whole
  // coefficient phase: ARM, WAIT, LENGTH coefficients, 3 settle cycles
  task automatic start_frame(input bit do_wr, input int a, input int re, input int im);
    int   b;
    obs_t o;
    bus.start = 1'b1;
    if (do_wr) begin
      bus.coeffWrEn   = 1'b1;
      bus.coeffWrAddr = AW'(a);
      bus.coeffWrRe   = DW'(re);
      bus.coeffWrIm   = DW'(im);
      if (a >= 0 && a < L) begin
        m_re[IW'(a)] = DW'(re);
        m_im[IW'(a)] = DW'(im);
      end
    end
    tb_busy = 1'b1;
    b = cyc;
    o = ev_busy(); o.lc = 1'b1;
    push(b + 1, o);
    push(b + 2, ev_busy());
    for (int k = 0; k < L; k++) begin
      o = ev_busy();
`ifdef COMPLEX_FIR_FEEDER_CONJ_COEFF_EN
      o.cre = m_re[IW'(L - 1 - k)];
      o.cim = sat_neg(m_im[IW'(L - 1 - k)]);
`else
      o.cre = m_re[IW'(k)];
      o.cim = m_im[IW'(k)];
`endif
      push(b + 3 + k, o);
    end
    push(b + 3 + L, ev_busy());
    push(b + 4 + L, ev_busy());
    o = ev_busy(); o.cs = 1'b1;
    push(b + 5 + L, o);
    @(negedge clock);
    bus.start     = 1'b0;
    bus.coeffWrEn = 1'b0;
  endtask

  // offer one sample until accepted; on the last one push flush/stop/done
  task automatic send(input int re, input int im, input bit last);
    bit   ok;
    int   p;
    obs_t o;
    ok          = 1'b0;
    bus.inValid = 1'b1;
    bus.inRe    = SW'(re);
    bus.inIm    = SW'(im);
    bus.inLast  = last;
    for (int n = 0; n < 100 && !ok; n++) begin
      if (bus.inReady) begin
        ok = 1'b1;
        p  = cyc;
        o = ev_busy(); o.ld = 1'b1; o.dre = SW'(re); o.dim = SW'(im);
        push(p + 1, o);
        if (last) begin
          for (int k = 0; k < L; k++) begin
            o = ev_busy(); o.ld = 1'b1;
            push(p + 2 + k, o);
          end
          o = ev_busy(); o.stop = 1'b1;
          push(p + 2 + L, o);
          o = ev_busy(); o.done = 1'b1;
          push(p + 3 + L, o);
          done_cyc = p + 3 + L;
        end
      end
      @(negedge clock);
    end
    bus.inValid = 1'b0;
    bus.inLast  = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual inReady never high required accepted within 100 cycles");
    end
  endtask

  task automatic finish_frame();
    for (int n = 0; n < 200 && cyc < done_cyc + 1; n++) @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0 || cyc != done_cyc + 1) begin
      errors++;
      $display("FAIL busy_after_done actual busy=%0b cyc=%0d required busy=0 cyc=%0d", bus.busy, cyc, done_cyc + 1);
    end
    tb_busy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    obs_t a;
    a = sample_dut();
    checks++;
    if (a !== '0 || bus.inReady !== 1'b0) begin
      errors++;
      $display("FAIL %s actual outputs=%h inReady=%0b required all 0", name, a, bus.inReady);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual simulation still running required finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.start       = 1'b0;
    bus.coeffWrEn   = 1'b0;
    bus.coeffWrAddr = '0;
    bus.coeffWrRe   = '0;
    bus.coeffWrIm   = '0;
    bus.inValid     = 1'b0;
    bus.inLast      = 1'b0;
    bus.inRe        = '0;
    bus.inIm        = '0;
    for (int i = 0; i < L; i++) begin
      m_re[IW'(i)] = '0;
      m_im[IW'(i)] = '0;
    end

    repeat (3) @(negedge clock);
    check_reset_outputs("power_on_reset");
    #2 resetN = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);

    // coefficient store; addresses 4 and 5 are out of range and must not alias
    wr(0, 1, -1);
    wr(1, 2, 0);
    wr(2, 3, 5);
    wr(3, -128, 127);
    wr(4, 99, 99);
    wr(5, 77, 77);

    // frame 1: three samples with 2-cycle bubbles, a write while busy
    start_frame(1'b0, 0, 0, 0);
    send(10, 0, 1'b0);
    wr(0, 50, 50);
    @(negedge clock);
    send(0, 0, 1'b0);
    @(negedge clock);
    @(negedge clock);
    send(-5, 3, 1'b1);
    finish_frame();

    // frame 2: single-sample frame (impulse)
    start_frame(1'b0, 0, 0, 0);
    send(7, -2, 1'b1);
    finish_frame();

    // frame 3: reset during COEFF abandons the frame and clears the store
    start_frame(1'b0, 0, 0, 0);
    repeat (3) @(negedge clock);
    #2;
    q.delete();
    mon_en = 1'b0;
    resetN = 1'b0;
    tb_busy = 1'b0;
    for (int i = 0; i < L; i++) begin
      m_re[IW'(i)] = '0;
      m_im[IW'(i)] = '0;
    end
    #1 check_reset_outputs("mid_frame_reset");
    @(negedge clock);
    check_reset_outputs("reset_held");
    #2 resetN = 1'b1;
    mon_en = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_reset actual %0b required 0", bus.busy);
    end

    // frame 4: write in the same cycle as start is seen by the frame
    start_frame(1'b1, 2, 3, 5);
    send(-1, 1, 1'b1);
    finish_frame();

    repeat (3) @(negedge clock);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual %0d pending required 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
